// File: rtl/vga_frame_reader.sv
// vga_frame_reader: VGA timing, framebuffer fetch with integer upscale, outputs aligned RD_LAT clocks behind the fetch.
// Free-running pixel clock, no backpressure. Define VGA_TESTPATTERN_EN to add the i_pattern colour-bar input.
module vga_frame_reader #(
    parameter int H_DISP      = 640,
    parameter int H_FP        = 16,
    parameter int H_PULSE     = 96,
    parameter int H_BP        = 48,
    parameter int V_DISP      = 480,
    parameter int V_FP        = 10,
    parameter int V_PULSE     = 2,
    parameter int V_BP        = 33,
    parameter int SYNC_POL    = 0,
    parameter int COLOR_W     = 4,
    parameter int SCALE       = 1,
    parameter int RD_LAT      = 1,
    parameter int SKIP_FRAMES = 2,
    parameter int ADDR_W      = 19
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
`ifdef VGA_TESTPATTERN_EN
    input  logic                   i_pattern,
`endif
    input  logic [3*COLOR_W-1:0]   i_pix_data,
    output logic [ADDR_W-1:0]      o_pix_addr,
    output logic                   o_pix_rd,
    output logic [9:0]             o_VGA_x,
    output logic [9:0]             o_VGA_y,
    output logic                   o_VGA_hsync,
    output logic                   o_VGA_vsync,
    output logic                   o_VGA_video,
    output logic [COLOR_W-1:0]     o_VGA_red,
    output logic [COLOR_W-1:0]     o_VGA_green,
    output logic [COLOR_W-1:0]     o_VGA_blue,
    output logic                   o_frame_start
);

    localparam int H_TOT = H_DISP + H_FP + H_PULSE + H_BP;
    localparam int V_TOT = V_DISP + V_FP + V_PULSE + V_BP;
    localparam int CW    = 12;
    localparam int FB_W  = H_DISP / SCALE;

    localparam logic [CW-1:0] HC_LAST  = CW'(H_TOT - 1);
    localparam logic [CW-1:0] VC_LAST  = CW'(V_TOT - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_DISP);
    localparam logic [CW-1:0] V_ACT    = CW'(V_DISP);
    localparam logic [CW-1:0] H_ACT_LS = CW'(H_DISP - 1);
    localparam logic [CW-1:0] HS_ON    = CW'(H_DISP + H_FP);
    localparam logic [CW-1:0] HS_OFF   = CW'(H_DISP + H_FP + H_PULSE);
    localparam logic [CW-1:0] VS_ON    = CW'(V_DISP + V_FP);
    localparam logic [CW-1:0] VS_OFF   = CW'(V_DISP + V_FP + V_PULSE);

    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(FB_W);
    localparam logic [2:0]        REP_LAST  = 3'(SCALE - 1);
    localparam logic [3:0]        SKIP_LAST = 4'((SKIP_FRAMES == 0) ? 0 : SKIP_FRAMES - 1);
    localparam logic              SYNC_ON   = (SYNC_POL != 0);

    typedef enum logic {
        ST_SKIP,
        ST_READ
    } state_t;

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       video;
        logic       rd_flag;
        logic       fs;
        logic [9:0] x;
        logic [9:0] y;
    } pipe_t;

    localparam pipe_t PIPE_RST = '{hsync: !SYNC_ON, vsync: !SYNC_ON, video: 1'b0,
                                   rd_flag: 1'b0, fs: 1'b0, x: 10'd0, y: 10'd0};

    logic [CW-1:0]     hc_q, hc_d, vc_q, vc_d;
    state_t            state_q, state_d;
    logic [3:0]        skip_q, skip_d;
    logic [ADDR_W-1:0] col_q, col_d, base_q, base_d, hold_q, hold_d;
    logic [2:0]        rep_x_q, rep_x_d, rep_y_q, rep_y_d;
    pipe_t             pipe_q [RD_LAT];
    pipe_t             pipe_d [RD_LAT];

    logic              active, frame_end, line_wrap, rd;
    logic [ADDR_W-1:0] fetch_addr;
    pipe_t             s0;
    pipe_t             out_s;
    logic [3*COLOR_W-1:0] rgb;

    always_comb begin
        active     = (hc_q < H_ACT) && (vc_q < V_ACT);
        line_wrap  = (hc_q == HC_LAST);
        frame_end  = line_wrap && (vc_q == VC_LAST);
        rd         = active && (state_q == ST_READ);
        fetch_addr = base_q + col_q;
    end

    // Timing counters and frame-skip FSM
    always_comb begin
        hc_d    = line_wrap ? '0 : hc_q + 1'b1;
        vc_d    = vc_q;
        if (line_wrap) begin
            vc_d = (vc_q == VC_LAST) ? '0 : vc_q + 1'b1;
        end
        state_d = state_q;
        skip_d  = skip_q;
        if (state_q == ST_SKIP) begin
            if (SKIP_FRAMES == 0) begin
                state_d = ST_READ;
            end else if (frame_end) begin
                if (skip_q == SKIP_LAST) begin
                    state_d = ST_READ;
                end else begin
                    skip_d = skip_q + 1'b1;
                end
            end
        end
    end

    // Fetch pointer tracks the pixel currently at (hc_q, vc_q); it advances in SKIP too
    // so that a partial first frame after a zero-skip reset still fetches the right words.
    always_comb begin
        col_d   = col_q;
        base_d  = base_q;
        rep_x_d = rep_x_q;
        rep_y_d = rep_y_q;
        hold_d  = rd ? fetch_addr : hold_q;
        if (frame_end) begin
            col_d   = '0;
            base_d  = '0;
            rep_x_d = '0;
            rep_y_d = '0;
        end else if (active) begin
            if (hc_q == H_ACT_LS) begin
                col_d   = '0;
                rep_x_d = '0;
                if (rep_y_q == REP_LAST) begin
                    rep_y_d = '0;
                    base_d  = base_q + LINE_STEP;
                end else begin
                    rep_y_d = rep_y_q + 1'b1;
                end
            end else if (rep_x_q == REP_LAST) begin
                rep_x_d = '0;
                col_d   = col_q + 1'b1;
            end else begin
                rep_x_d = rep_x_q + 1'b1;
            end
        end
    end

    always_comb begin
        s0.hsync   = ((hc_q >= HS_ON) && (hc_q < HS_OFF)) ? SYNC_ON : !SYNC_ON;
        s0.vsync   = ((vc_q >= VS_ON) && (vc_q < VS_OFF)) ? SYNC_ON : !SYNC_ON;
        s0.video   = active;
        s0.rd_flag = (state_q == ST_READ);
        s0.fs      = rd && (hc_q == '0) && (vc_q == '0);
        s0.x       = hc_q[9:0];
        s0.y       = vc_q[9:0];
        pipe_d[0]  = s0;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hc_q    <= '0;
            vc_q    <= '0;
            state_q <= ST_SKIP;
            skip_q  <= '0;
            col_q   <= '0;
            base_q  <= '0;
            rep_x_q <= '0;
            rep_y_q <= '0;
            hold_q  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= PIPE_RST;
            end
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            state_q <= state_d;
            skip_q  <= skip_d;
            col_q   <= col_d;
            base_q  <= base_d;
            rep_x_q <= rep_x_d;
            rep_y_q <= rep_y_d;
            hold_q  <= hold_d;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign out_s = pipe_q[RD_LAT-1];

`ifdef VGA_TESTPATTERN_EN
    localparam logic [9:0] BAR_W = 10'(H_DISP / 8);
    logic [2:0] bar_k;
    assign bar_k = 3'(out_s.x / BAR_W);
`endif

    // Colour is gated by the delayed flags so it lines up with the BRAM word returning now.
    always_comb begin
        rgb = '0;
        if (out_s.video) begin
`ifdef VGA_TESTPATTERN_EN
            if (i_pattern || !out_s.rd_flag) begin
                rgb = {{COLOR_W{bar_k[2]}}, {COLOR_W{bar_k[1]}}, {COLOR_W{bar_k[0]}}};
            end else begin
                rgb = i_pix_data;
            end
`else
            if (out_s.rd_flag) begin
                rgb = i_pix_data;
            end
`endif
        end
    end

    assign o_pix_rd      = rd;
    assign o_pix_addr    = rd ? fetch_addr : hold_q;
    assign o_VGA_x       = out_s.x;
    assign o_VGA_y       = out_s.y;
    assign o_VGA_hsync   = out_s.hsync;
    assign o_VGA_vsync   = out_s.vsync;
    assign o_VGA_video   = out_s.video;
    assign o_frame_start = out_s.fs;
    assign o_VGA_red     = rgb[3*COLOR_W-1:2*COLOR_W];
    assign o_VGA_green   = rgb[2*COLOR_W-1:COLOR_W];
    assign o_VGA_blue    = rgb[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: two reduced-timing instances (A: SCALE=1 RD_LAT=1 SKIP=2, B: SCALE=2 RD_LAT=3 SKIP=1).
// Timing: 16+2+3+3 = 24 clocks/line, 8+1+2+1 = 12 lines/frame, 288 clocks/frame.
module tb_vga_frame_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_rd, b_rd;
    logic [18:0] a_addr, b_addr;
    logic [9:0]  a_x, a_y, b_x, b_y;
    logic        a_hs, a_vs, a_vid, a_fs, b_hs, b_vs, b_vid, b_fs;
    logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b;
    logic [11:0] a_d1, b_d1, b_d2, b_d3;

    // BRAM models: word value equals its address, latency 1 (A) and 3 (B)
    always @(posedge clk) begin
        a_d1 <= a_addr[11:0];
        b_d1 <= b_addr[11:0];
        b_d2 <= b_d1;
        b_d3 <= b_d2;
    end

`ifdef VGA_TESTPATTERN_EN
    logic pattern = 1'b0;
`endif

    vga_frame_reader #(
        .H_DISP(16), .H_FP(2), .H_PULSE(3), .H_BP(3),
        .V_DISP(8), .V_FP(1), .V_PULSE(2), .V_BP(1),
        .SYNC_POL(0), .COLOR_W(4), .SCALE(1), .RD_LAT(1), .SKIP_FRAMES(2), .ADDR_W(19)
    ) dut_a (
        .i_clk(clk), .i_rst(rst),
`ifdef VGA_TESTPATTERN_EN
        .i_pattern(pattern),
`endif
        .i_pix_data(a_d1), .o_pix_addr(a_addr), .o_pix_rd(a_rd),
        .o_VGA_x(a_x), .o_VGA_y(a_y), .o_VGA_hsync(a_hs), .o_VGA_vsync(a_vs),
        .o_VGA_video(a_vid), .o_VGA_red(a_r), .o_VGA_green(a_g), .o_VGA_blue(a_b),
        .o_frame_start(a_fs)
    );

    vga_frame_reader #(
        .H_DISP(16), .H_FP(2), .H_PULSE(3), .H_BP(3),
        .V_DISP(8), .V_FP(1), .V_PULSE(2), .V_BP(1),
        .SYNC_POL(0), .COLOR_W(4), .SCALE(2), .RD_LAT(3), .SKIP_FRAMES(1), .ADDR_W(19)
    ) dut_b (
        .i_clk(clk), .i_rst(rst),
`ifdef VGA_TESTPATTERN_EN
        .i_pattern(1'b0),
`endif
        .i_pix_data(b_d3), .o_pix_addr(b_addr), .o_pix_rd(b_rd),
        .o_VGA_x(b_x), .o_VGA_y(b_y), .o_VGA_hsync(b_hs), .o_VGA_vsync(b_vs),
        .o_VGA_video(b_vid), .o_VGA_red(b_r), .o_VGA_green(b_g), .o_VGA_blue(b_b),
        .o_frame_start(b_fs)
    );

    typedef enum int {S_RD, S_ADDR, S_X, S_Y, S_HS, S_VS, S_VID, S_RGB, S_FS} sel_t;

    typedef struct {
        int   n;
        bit   b;
        sel_t sel;
        int   exp;
    } vec_t;

    vec_t vecs[$];
    int   cyc;
    int   checks;
    int   failures;

`ifdef VGA_TESTPATTERN_EN
    localparam int SKIP_RGB_A = 12'h00F;
`else
    localparam int SKIP_RGB_A = 0;
`endif

    task automatic add(input int n, input bit b, input sel_t s, input int e);
        vec_t v;
        v.n = n; v.b = b; v.sel = s; v.exp = e;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] get(input bit b, input sel_t s);
        case (s)
            S_RD:   return b ? 32'(b_rd) : 32'(a_rd);
            S_ADDR: return b ? 32'(b_addr) : 32'(a_addr);
            S_X:    return b ? 32'(b_x) : 32'(a_x);
            S_Y:    return b ? 32'(b_y) : 32'(a_y);
            S_HS:   return b ? 32'(b_hs) : 32'(a_hs);
            S_VS:   return b ? 32'(b_vs) : 32'(a_vs);
            S_VID:  return b ? 32'(b_vid) : 32'(a_vid);
            S_RGB:  return b ? 32'({b_r, b_g, b_b}) : 32'({a_r, a_g, a_b});
            S_FS:   return b ? 32'(b_fs) : 32'(a_fs);
            default: return 32'hDEAD;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc = cyc + 1;
    endtask

    task automatic run_vecs();
        logic [31:0] act;
        foreach (vecs[i]) begin
            while (cyc < vecs[i].n) step();
            act = get(vecs[i].b, vecs[i].sel);
            checks = checks + 1;
            if (act !== 32'(vecs[i].exp)) begin
                failures = failures + 1;
                $display("FAIL %s_%s@%0d: got 0x%0h expected 0x%0h",
                         vecs[i].b ? "B" : "A", vecs[i].sel.name(), vecs[i].n, act, vecs[i].exp);
            end
        end
        vecs.delete();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state, sync timing, skip frames, fetch addresses and aligned pixels
        add(0, 0, S_RD, 0);   add(0, 0, S_ADDR, 0); add(0, 0, S_HS, 1); add(0, 0, S_VS, 1);
        add(0, 0, S_VID, 0);  add(0, 0, S_RGB, 0);  add(0, 0, S_FS, 0); add(0, 0, S_X, 0);
        add(0, 0, S_Y, 0);    add(0, 1, S_RD, 0);   add(0, 1, S_HS, 1); add(0, 1, S_VID, 0);
        add(18, 0, S_HS, 1);  add(19, 0, S_HS, 0);  add(20, 1, S_HS, 1);
        add(21, 0, S_HS, 0);  add(21, 1, S_HS, 0);  add(22, 0, S_HS, 1);
        add(23, 1, S_HS, 0);  add(24, 1, S_HS, 1);
        add(100, 0, S_VID, 1); add(100, 0, S_RGB, SKIP_RGB_A); add(100, 0, S_RD, 0);
        add(216, 0, S_VS, 1); add(217, 0, S_VS, 0); add(264, 0, S_VS, 0); add(265, 0, S_VS, 1);
        add(287, 1, S_RD, 0); add(288, 1, S_RD, 1); add(288, 1, S_ADDR, 0);
        add(289, 1, S_ADDR, 0); add(290, 1, S_ADDR, 1); add(290, 1, S_FS, 0);
        add(291, 1, S_FS, 1); add(291, 1, S_X, 0); add(291, 1, S_Y, 0);
        add(291, 1, S_VID, 1); add(291, 1, S_RGB, 0); add(292, 1, S_FS, 0);
        add(295, 1, S_X, 4);  add(295, 1, S_RGB, 2); add(303, 1, S_ADDR, 7);
        add(317, 1, S_ADDR, 2); add(336, 1, S_ADDR, 8); add(339, 1, S_ADDR, 9);
        add(342, 1, S_X, 3);  add(342, 1, S_Y, 2);  add(342, 1, S_RGB, 9);
        add(471, 1, S_ADDR, 31); add(472, 1, S_RD, 0);
        add(575, 0, S_RD, 0); add(576, 0, S_RD, 1); add(576, 0, S_ADDR, 0);
        add(576, 1, S_RD, 1); add(576, 1, S_ADDR, 0);
        add(577, 0, S_X, 0);  add(577, 0, S_Y, 0);  add(577, 0, S_FS, 1);
        add(577, 0, S_VID, 1); add(577, 0, S_RGB, 0);
        add(578, 0, S_X, 1);  add(578, 0, S_RGB, 1); add(578, 0, S_FS, 0);
        add(581, 0, S_ADDR, 5); add(603, 0, S_ADDR, 19);
        add(604, 0, S_X, 3);  add(604, 0, S_Y, 1);  add(604, 0, S_RGB, 12'h013);
        add(759, 0, S_ADDR, 127); add(759, 0, S_RD, 1);
        add(760, 0, S_RD, 0); add(760, 0, S_ADDR, 127); add(760, 0, S_RGB, 127);
        add(761, 0, S_RGB, 0); add(761, 0, S_VID, 0);
        add(864, 0, S_RD, 1); add(864, 0, S_ADDR, 0);
        add(988, 0, S_RD, 1); add(988, 0, S_ADDR, 5 * 16 + 4);
        run_vecs();

        // One-clock reset at line 5 of a READ frame: reset values next clock, skip re-applies
        pulse_reset();
        add(0, 0, S_RD, 0);   add(0, 0, S_ADDR, 0); add(0, 0, S_HS, 1); add(0, 0, S_VS, 1);
        add(0, 0, S_VID, 0);  add(0, 0, S_RGB, 0);  add(0, 0, S_FS, 0); add(0, 0, S_X, 0);
        add(0, 0, S_Y, 0);    add(0, 1, S_RD, 0);   add(0, 1, S_FS, 0); add(0, 1, S_VID, 0);
        add(287, 1, S_RD, 0); add(288, 1, S_RD, 1); add(288, 1, S_ADDR, 0);
        add(575, 0, S_RD, 0); add(576, 0, S_RD, 1); add(576, 0, S_ADDR, 0);
        run_vecs();

`ifdef VGA_TESTPATTERN_EN
        // Colour bars, 2 pixels wide at H_DISP=16, on line 1 of a READ frame
        pattern = 1'b1;
        add(601, 0, S_RGB, 12'h000); add(603, 0, S_RGB, 12'h00F);
        add(610, 0, S_RGB, 12'hF00); add(616, 0, S_RGB, 12'hFFF);
        add(616, 0, S_RD, 0);
        run_vecs();
        pattern = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
